// File: rtl/data_feed.sv
// data_feed: loads 3x3 matrices A and B byte-serially, then drives them skewed onto a systolic array's edges.
// Optional DATA_FEED_REUSE_EN: keep storage after DONE and return to READY for replay.
module data_feed #(
  parameter int DW    = 8,
  parameter int FLUSH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          start,
  output logic [DW-1:0] a_row0,
  output logic [DW-1:0] a_row1,
  output logic [DW-1:0] a_row2,
  output logic [DW-1:0] b_col0,
  output logic [DW-1:0] b_col1,
  output logic [DW-1:0] b_col2,
  output logic          feed_valid,
  output logic          busy,
  output logic          done
);
`ifdef DATA_FEED_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  typedef enum logic [2:0] {S_LOAD, S_READY, S_FEED, S_FLUSH, S_DONE} state_t;
  state_t        state, state_nxt;
  logic [DW-1:0] mem [18];
  logic [4:0]    idx, wr_idx;
  logic [3:0]    t, t_nxt;
  logic [DW-1:0] a_nxt [3];
  logic [DW-1:0] b_nxt [3];
  logic [DW-1:0] a_q [3];
  logic [DW-1:0] b_q [3];
  logic          hs;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_LOAD;
    else      state <= state_nxt;
  always_comb begin
    state_nxt = S_LOAD;
    case (state)
      S_LOAD:  state_nxt = (hs && idx == 5'd17) ? S_READY : S_LOAD;
      S_READY: state_nxt = start ? S_FEED : hs ? S_LOAD : S_READY;
      S_FEED:  state_nxt = (t == 4'd4) ? S_FLUSH : S_FEED;
      S_FLUSH: state_nxt = (t == 4'(FLUSH - 1)) ? S_DONE : S_FLUSH;
      S_DONE:  state_nxt = REUSE ? S_READY : S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end
  // A start on the same edge as a READY-state byte wins, so the byte is refused.
  always_comb begin
    in_ready   = rst && (state == S_LOAD || (REUSE && state == S_READY && !start));
    feed_valid = state == S_FEED || state == S_FLUSH;
    busy       = state == S_FEED || state == S_FLUSH || state == S_DONE;
    done       = state == S_DONE;
    hs         = in_valid && in_ready;
    wr_idx     = state == S_LOAD ? idx : 5'd0;
    t_nxt      = (state_nxt == state && (state == S_FEED || state == S_FLUSH)) ? t + 4'd1 : 4'd0;
  end
  // Row i sees A[i][t-i] at slot 3i+(t-i); column j sees B[t-j][j] at slot 9+3(t-j)+j.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      a_nxt[i] = (state_nxt == S_FEED && int'(t_nxt) >= i && int'(t_nxt) <= i + 2)
                 ? mem[5'(2 * i + int'(t_nxt))] : '0;
      b_nxt[i] = (state_nxt == S_FEED && int'(t_nxt) >= i && int'(t_nxt) <= i + 2)
                 ? mem[5'(9 + 3 * int'(t_nxt) - 2 * i)] : '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx <= '0;
      t   <= '0;
      for (int k = 0; k < 18; k++) mem[k] <= '0;
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      t   <= t_nxt;
      idx <= (hs && state == S_LOAD) ? (idx == 5'd17 ? 5'd0 : idx + 5'd1)
           : hs ? 5'd1 : (state == S_DONE ? 5'd0 : idx);
      for (int k = 0; k < 18; k++)
        mem[k] <= (state == S_DONE && !REUSE) ? '0 : (hs && wr_idx == 5'(k)) ? in_data : mem[k];
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= a_nxt[i];
        b_q[i] <= b_nxt[i];
      end
    end
  assign a_row0 = a_q[0];
  assign a_row1 = a_q[1];
  assign a_row2 = a_q[2];
  assign b_col0 = b_q[0];
  assign b_col1 = b_q[1];
  assign b_col2 = b_q[2];
endmodule

// File: tb/tb_data_feed.sv
// tb_data_feed: directed self-checking bench for data_feed (FLUSH=3).
module tb_data_feed;
`ifdef DATA_FEED_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0, start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, feed_valid, busy, done;
  logic [7:0] a_row0, a_row1, a_row2, b_col0, b_col1, b_col2;
  logic [7:0] ma [9];
  logic [7:0] mb [9];
  int vectors = 0, miscompares = 0;
  data_feed #(.DW(8), .FLUSH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .a_row0(a_row0), .a_row1(a_row1), .a_row2(a_row2),
    .b_col0(b_col0), .b_col1(b_col1), .b_col2(b_col2),
    .feed_valid(feed_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk6(input string tag, input logic [7:0] a0, a1, a2, b0, b1, b2);
    chk({tag, " a_row0"}, a_row0, a0);
    chk({tag, " a_row1"}, a_row1, a1);
    chk({tag, " a_row2"}, a_row2, a2);
    chk({tag, " b_col0"}, b_col0, b0);
    chk({tag, " b_col1"}, b_col1, b1);
    chk({tag, " b_col2"}, b_col2, b2);
  endtask
  function automatic logic [7:0] ea(input int i, input int t);
    return (t - i >= 0 && t - i <= 2) ? ma[i * 3 + t - i] : 8'h00;
  endfunction
  function automatic logic [7:0] eb(input int j, input int t);
    return (t - j >= 0 && t - j <= 2) ? mb[(t - j) * 3 + j] : 8'h00;
  endfunction
  task automatic chk_feed(input int t);
    chk6($sformatf("feed t=%0d", t), ea(0, t), ea(1, t), ea(2, t), eb(0, t), eb(1, t), eb(2, t));
    chk($sformatf("feed_valid t=%0d", t), feed_valid, 1);
  endtask
  task automatic load_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      in_valid = 1'b1;
      in_data  = k < 9 ? ma[k] : mb[k - 9];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask
  task automatic tail_checks;
    for (int f = 0; f < 3; f++) begin
      chk6($sformatf("flush %0d", f), 0, 0, 0, 0, 0, 0);
      chk($sformatf("flush %0d feed_valid", f), feed_valid, 1);
      chk($sformatf("flush %0d done", f), done, 0);
      @(negedge clk);
    end
    chk("done pulse", done, 1);
    chk("done feed_valid", feed_valid, 0);
    chk("done busy", busy, 1);
    chk("done in_ready", in_ready, 0);
    @(negedge clk);
    chk("after done", done, 0);
    chk("after done busy", busy, 0);
    chk("after done in_ready", in_ready, 1);
  endtask
  initial begin
    #3;
    chk("reset in_ready", in_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset feed_valid", feed_valid, 0);
    chk6("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post-reset in_ready", in_ready, 1);
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      ma[k] = 8'(k + 1);
      mb[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
    end
    load_range(0, 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start in LOAD busy", busy, 0);
    chk("start in LOAD feed_valid", feed_valid, 0);
    chk("start in LOAD in_ready", in_ready, 1);
    chk6("start in LOAD", 0, 0, 0, 0, 0, 0);
    load_range(10, 17);
    chk("loaded in_ready", in_ready, REUSE ? 1 : 0);
    chk("loaded busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: chk6("t=0", 1, 0, 0, 1, 0, 0);
        1: chk6("t=1", 2, 4, 0, 0, 0, 0);
        2: chk6("t=2", 3, 5, 7, 0, 1, 0);
        3: chk6("t=3", 0, 6, 8, 0, 0, 0);
        default: chk6("t=4", 0, 0, 9, 0, 0, 1);
      endcase
      chk($sformatf("t=%0d feed_valid", t), feed_valid, 1);
      chk($sformatf("t=%0d in_ready", t), in_ready, 0);
      in_valid = t[0];
      in_data  = 8'hFF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int f = 0; f < 3; f++) begin
      chk6($sformatf("held flush %0d", f), 0, 0, 0, 0, 0, 0);
      chk($sformatf("held flush %0d feed_valid", f), feed_valid, 1);
      if (f == 2) start = 1'b0;
      @(negedge clk);
    end
    chk("held done", done, 1);
    @(negedge clk);
    chk("held after done", done, 0);
    chk("held after done busy", busy, 0);
    chk("held after done in_ready", in_ready, 1);
    for (int k = 0; k < 9; k++) begin
      ma[k] = 8'(10 + k);
      mb[k] = 8'(21 + k);
    end
    load_range(0, 16);
    chk("17 bytes in_ready", in_ready, 1);
    load_range(17, 17);
    chk("18 bytes in_ready", in_ready, REUSE ? 1 : 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk_feed(t);
      if (t < 2) @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk6("async reset", 0, 0, 0, 0, 0, 0);
    chk("async reset feed_valid", feed_valid, 0);
    chk("async reset busy", busy, 0);
    chk("async reset in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release in_ready", in_ready, 1);
    @(negedge clk);
    load_range(0, 16);
    chk("reload 17 in_ready", in_ready, 1);
    load_range(17, 17);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      chk_feed(t);
      @(negedge clk);
    end
    tail_checks();
`ifdef DATA_FEED_REUSE_EN
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    chk("start+valid in_ready", in_ready, 0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      chk_feed(t);
      @(negedge clk);
    end
    tail_checks();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_feed.md
Name: data_feed

Overview:
- Input-side companion to the 3x3 systolic matrix multiplier's output collector.
- Serially loads a 3x3 matrix A and a 3x3 matrix B, one byte per handshake.
- On start, drives the array edges: rows of A skewed onto the left edge, columns of B skewed onto the top edge.
- Then zero-flushes so the array drains, and pulses done.

Parameters:
DW, 8, element width in bits. Matches the 8-bit diagonal outputs collected downstream.
FLUSH, 3, number of all-zero cycles driven after the skewed feed. Legal range 1..15.

Ports:
clk  input  1  clock; all state updates on posedge clk
rst  input  1  asynchronous, active-low reset
in_valid  input  1  load byte valid
in_ready  output  1  block can accept a load byte
in_data  input  DW  load byte: A row-major (A00..A22), then B row-major (B00..B22), 18 bytes total
start  input  1  begin feed; honoured only in READY
a_row0, a_row1, a_row2  output  DW each  left-edge inputs to array rows 0..2
b_col0, b_col1, b_col2  output  DW each  top-edge inputs to array columns 0..2
feed_valid  output  1  high during FEED and FLUSH cycles
busy  output  1  high in FEED, FLUSH, DONE
done  output  1  one-cycle pulse at end of flush

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, load index=0, phase counter=0.
  - All 18 storage bytes cleared to 0.
  - All a_row*/b_col* outputs = 0; feed_valid=0, busy=0, done=0.
  - in_ready=1 only after rst deasserts.
  - Reset asserted mid-FEED or mid-FLUSH zeroes the edge outputs immediately, without waiting for a clock.
- States: LOAD -> READY -> FEED -> FLUSH -> DONE -> LOAD.
- LOAD:
  - in_ready=1.
  - Each posedge with in_valid=1 writes in_data to slot idx (0..8 = A, 9..17 = B) and increments idx.
  - The write at idx=17 moves to READY and resets idx to 0.
  - start is ignored in LOAD.
- READY:
  - in_ready=0; in_valid is ignored.
  - start=1 at a posedge moves to FEED with phase t=0.
- FEED, t = 0..4 (five cycles), registered outputs valid during cycle t:
  - a_row_i = A[i][t-i] when 0 <= t-i <= 2, else 0.
  - b_col_j = B[t-j][j] when 0 <= t-j <= 2, else 0.
  - feed_valid=1.
  - After t=4, go to FLUSH.
- FLUSH:
  - All edge outputs = 0; feed_valid=1.
  - Lasts exactly FLUSH cycles, then DONE.
- DONE:
  - done=1 for exactly one cycle, feed_valid=0, edge outputs 0.
  - Next state LOAD.
  - Storage cleared to 0 on this transition (overridden by the optional feature).
- Latency: first skewed data appears on the cycle after the start edge. done asserts 5+FLUSH cycles after the first feed cycle.
- in_ready=0 in READY, FEED, FLUSH, DONE. A load handshake occurs only when in_valid and in_ready are both 1.
- start held high across several cycles triggers a single feed. Re-triggering requires a new pass through LOAD/READY.
- No arithmetic is performed; values are passed unmodified at DW bits.

Optional Feature:
- Macro: DATA_FEED_REUSE_EN.
- Defined:
  - DONE returns to READY instead of LOAD, and storage is retained.
  - A further start replays an identical feed.
  - In READY, in_ready=1. A handshake there overwrites slot 0, returns to LOAD with idx=1, and a full 18-byte reload follows.
  - A start and in_valid arriving on the same edge in READY: start wins and the byte is not accepted (in_ready is forced 0 that cycle when start=1).
- Undefined: behaviour as above — storage cleared at DONE, return to LOAD, in_ready=0 in READY.

Test Plan:
- Load A=1..9 row-major and B=identity, start -> feed cycles as follows:
  - t=0: a_row=(1,0,0), b_col=(1,0,0)
  - t=1: a_row=(2,4,0), b_col=(0,0,0)
  - t=2: a_row=(3,5,7), b_col=(0,1,0)
  - t=3: a_row=(0,6,8), b_col=(0,0,0)
  - t=4: a_row=(0,0,9), b_col=(0,0,1)
  - Then 3 zero cycles with feed_valid=1, then done=1 for one cycle.
- Assert start during LOAD after 10 bytes -> no state change, outputs stay 0, loading continues at idx=10.
- Hold start high for 8 cycles in READY -> exactly one feed, one done pulse, state returns to LOAD.
- Drive rst low during FEED at t=2 -> all edge outputs 0 and feed_valid=0 immediately. After release, in_ready=1 and a reload of 18 bytes is required.
- Toggle in_valid during FEED with in_data=0xFF -> not accepted, storage unchanged, and the next load starts at idx=0.
- With DATA_FEED_REUSE_EN: after done, a second start with no reload -> feed identical to the first; with start and in_valid on the same edge in READY, the feed occurs and the byte is dropped.
